rr_arbiter4x16: RTL and testbench

Round-robin arbiter and sequencer sharing one 16-bit output port between four requesters. It owns the select lines of an internal 4-way 16-bit word multiplexer and grants the port to one requester at a time. Each grant covers a burst of beats under a valid/ready handshake. It sits between the four word sources (CPU write path, DMA, debug, I/O) and the single downstream sink (for example the RAM write port).

---
 rtl/rr_arbiter4x16.sv | 119 +++++++++++
 tb/tb_rr_arbiter4x16.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4x16.sv
// Round-robin arbiter sharing one 16-bit output port between four requesters.
// Each grant carries a valid/ready burst that ends on last, on the MAX_BURST cap, or on abandon.
module rr_arbiter4x16 #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic {ARB, GRANT} state_t;

    localparam logic [3:0] MAX_BURST_W = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  count_q, count_d;

    logic        found;
    logic [1:0]  winner;
    logic [1:0]  scan_idx;
    logic        accept;
    logic [3:0]  count_inc;
    logic        release_grant;

    // Scan ptr, ptr+1, ... (mod 4) and take the first requester found.
    always_comb begin
        found    = 1'b0;
        winner   = ptr_q;
        scan_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign busy          = (state_q == GRANT);
    assign out_valid     = busy && req[sel_q];
    assign accept        = out_valid && out_ready;
    assign count_inc     = count_q + 4'd1;
    assign release_grant = (accept && (last[sel_q] || count_inc == MAX_BURST_W)) || !req[sel_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d = 4'b0001 << winner;
                    sel_d   = winner;
                    count_d = 4'd0;
                    state_d = GRANT;
                end else begin
                    grant_d = 4'd0;
                end
            end
            GRANT: begin
                if (accept) begin
                    count_d = count_inc;
                end
                // The releasing requester drops to lowest priority; sel keeps its value.
                if (release_grant) begin
                    state_d = ARB;
                    grant_d = 4'd0;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            grant_q <= 4'd0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    out_data = in0;
            2'd1:    out_data = in1;
            2'd2:    out_data = in2;
            default: out_data = in3;
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_rr_arbiter4x16.sv
// Directed testbench for rr_arbiter4x16: reset, single requester, rotation, burst cap,
// backpressure, abandon and asynchronous reset, with hand-computed expectations.
module tb_rr_arbiter4x16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] in0, in1, in2, in3;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int tests_run = 0;
    int failures  = 0;
    int beats     = 0;

    rr_arbiter4x16 #(.MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .last     (last),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .grant    (grant),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Count beats accepted at each rising edge, using pre-edge values.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) beats <= beats + 1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0; last = 4'b0; out_ready = 1'b0;
        in0 = 16'h0000; in1 = 16'h1111; in2 = 16'h2222; in3 = 16'h3333;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111; last = 4'b0; out_ready = 1'b1;
        in0 = 16'h0; in1 = 16'h0; in2 = 16'h0; in3 = 16'h0;
        step();
        tests_run++;
        if ({grant, sel, busy, out_valid} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: grant=%b sel=%0d busy=%b valid=%b, want all 0", grant, sel, busy, out_valid);
        end
        rst_n = 1'b1;
        req = 4'b0;
        step();
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: grant=%b busy=%b, want 0000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        int b0;
        do_reset();
        req = 4'b0010; in1 = 16'hBEEF; out_ready = 1'b1; last = 4'b0;
        b0 = beats;
        step();
        #1;
        tests_run++;
        if (grant !== 4'b0010 || sel !== 2'd1 || busy !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_grant: grant=%b sel=%0d busy=%b valid=%b, want 0010/1/1/1", grant, sel, busy, out_valid);
        end
        tests_run++;
        if (out_data !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL single_data: got %h want BEEF", out_data);
        end
        step();
        step();
        last = 4'b0010;
        tests_run++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL single_hold: grant=%b want 0010", grant);
        end
        step();
        last = 4'b0000;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_release: grant=%b valid=%b want 0000/0", grant, out_valid);
        end
        tests_run++;
        if (beats - b0 !== 3) begin
            failures++;
            $display("[TB] FAIL single_beats: got %0d want 3", beats - b0);
        end
        step();
        tests_run++;
        if (grant !== 4'b0010 || sel !== 2'd1) begin
            failures++;
            $display("[TB] FAIL single_regrant: grant=%b sel=%0d want 0010/1", grant, sel);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            tests_run++;
            if (grant !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL rr_seq[%0d]: grant=%b want %b", i, grant, exp_seq[i]);
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [3:0] exp_seq [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                     4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
        do_reset();
        req = 4'b0101; last = 4'b0000; out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            tests_run++;
            if (grant !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL cap_seq[%0d]: grant=%b want %b", i, grant, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int b0;
        do_reset();
        req = 4'b1000; last = 4'b0000; out_ready = 1'b0; in3 = 16'hA000;
        step();
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            in3 = 16'hA000 + 16'(i);
            #1;
            tests_run++;
            if (grant !== 4'b1000 || sel !== 2'd3 || out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(i)) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: grant=%b sel=%0d valid=%b data=%h", i, grant, sel, out_valid, out_data);
            end
            step();
        end
        tests_run++;
        if (beats !== b0 || grant !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL bp_no_beat: beats=%0d grant=%b want %0d/1000", beats - b0, grant, 0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests_run++;
            if (grant !== (i < 4 ? 4'b1000 : 4'b0000) || beats - b0 !== i) begin
                failures++;
                $display("[TB] FAIL bp_resume[%0d]: grant=%b beats=%0d", i, grant, beats - b0);
            end
        end
    endtask

    task automatic test_abandon();
        do_reset();
        req = 4'b0011; last = 4'b0000; out_ready = 1'b1;
        step();
        step();
        req = 4'b0010;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || grant !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL abandon_valid: valid=%b grant=%b want 0/0001", out_valid, grant);
        end
        step();
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abandon_release: grant=%b busy=%b want 0000/0", grant, busy);
        end
        req = 4'b0011;
        step();
        tests_run++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL abandon_ptr: grant=%b want 0010", grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010; last = 4'b0010; out_ready = 1'b1;
        step();
        step();
        req = 4'b0100; last = 4'b0000;
        step();
        tests_run++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL ar_setup: grant=%b want 0100", grant);
        end
        step();
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ar_immediate: grant=%b valid=%b busy=%b want 0000/0/0", grant, out_valid, busy);
        end
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        tests_run++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            failures++;
            $display("[TB] FAIL ar_priority: grant=%b sel=%0d want 0001/0", grant, sel);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_abandon();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
